llc_trace_dispatch: RTL and testbench
=====================================

Name: llc_trace_dispatch

Overview:
- Upstream front end of the LLC model; sits directly ahead of the per-operation handlers (CPU read/write, snooped read/write/RWIM/invalidate).
- Accepts trace commands (opcode + 32-bit address) and buffers them in a small FIFO.
- Splits each address into tag/index, classifies the opcode and issues one operation at a time over a valid/ready dispatch bus.
- Sequences the clear (op 8) and print (op 9) control commands and keeps per-class statistics counters.

Parameters:
ADDR_W, 32, trace address width
OFFSET_W, 6, byte-offset bits (64 B line)
INDEX_W, 14, set-index bits (16K sets)
TAG_W, ADDR_W-INDEX_W-OFFSET_W (12), tag bits, derived
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
clk in 1 system clock
rst_n in 1 synchronous active-low reset
cmd_valid in 1 trace command present
cmd_ready out 1 FIFO can accept
cmd_op in 4 trace opcode
cmd_addr in ADDR_W trace address
dsp_valid out 1 operation offered to handlers
dsp_ready in 1 handler accepts
dsp_op out 4 opcode 0..6
dsp_snoop out 1 1 when dsp_op is 3..6
dsp_addr out ADDR_W full address (needed for snoop result reporting)
dsp_tag out TAG_W addr[ADDR_W-1 : INDEX_W+OFFSET_W]
dsp_index out INDEX_W addr[INDEX_W+OFFSET_W-1 : OFFSET_W]
clr_req out 1 clear cache/stats request, level
clr_done in 1 handler clear complete, 1-cycle pulse
print_pulse out 1 1-cycle print-contents strobe
bad_cmd out 1 1-cycle strobe for illegal opcode
fifo_level out $clog2(FIFO_DEPTH)+1 current occupancy
cnt_cpu_rd out 32 ops 0 and 2 dispatched
cnt_cpu_wr out 32 op 1 dispatched
cnt_snoop out 32 ops 3..6 dispatched
cnt_bad out 16 illegal opcodes dropped

Behaviour:
- Reset (rst_n=0 at clk edge): FIFO empty, state IDLE, all outputs 0 except cmd_ready=1. Reset mid-issue or mid-clear abandons the operation without a handshake.
- FIFO:
  - cmd_ready = !full (registered occupancy).
  - Push on cmd_valid&cmd_ready; no push while full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pushing continues in every state.
- FSM states: IDLE, ISSUE, CLEAR.
  - IDLE, FIFO empty: stay.
  - IDLE, head op 0..6: pop. Next cycle dsp_valid=1 with dsp_op/addr/tag/index/snoop registered from the popped entry. Go to ISSUE.
  - IDLE, head op 8: pop, clr_req=1 next cycle, go to CLEAR.
  - IDLE, head op 9: pop, print_pulse=1 for exactly 1 cycle, stay IDLE.
  - IDLE, head op 7 or 10..15: pop, bad_cmd=1 for 1 cycle, cnt_bad+1, stay IDLE.
  - ISSUE: all dsp_* held stable while dsp_valid&!dsp_ready. On dsp_valid&dsp_ready: dsp_valid=0 next cycle, matching counter +1, return to IDLE. Peak rate is one operation per 2 cycles.
  - CLEAR: clr_req held 1 until clr_done. On clr_done: clr_req=0, all four counters set to 0, return to IDLE. clr_done outside CLEAR is ignored.
- One FIFO pop at most per cycle; pops occur only in IDLE.
- Counters saturate at all-ones (no wrap).
- Zero-latency path: a command pushed into an empty FIFO is popped the following cycle. dsp_valid rises 2 cycles after the cmd handshake.

Test Plan:
- Push op 0, addr 0x1234_5678, dsp_ready=1 -> dsp_valid 2 cycles later; dsp_tag=0x123, dsp_index=0x1159, dsp_snoop=0; cnt_cpu_rd=1.
- Push op 3 addr 0xFFFF_FFC0 with dsp_ready=0 for 5 cycles -> dsp_* stable all 5 cycles; dsp_snoop=1, tag=0xFFF, index=0x3FFF; one handshake only; cnt_snoop=1.
- Hold dsp_ready=0, push 5 commands -> fifo_level reaches 4 and cmd_ready=0 while full. Release dsp_ready -> all 5 dispatched in order, no loss or duplication.
- Push ops 7, 9, 12 -> two bad_cmd pulses, one print_pulse, no dsp_valid; cnt_bad=2.
- Dispatch ops 1,1,4, then op 8; hold clr_done low 3 cycles -> clr_req high throughout; next queued op stays pending. On the clr_done pulse: all counters 0, then the pending op dispatches.
- Assert rst_n=0 during ISSUE with 2 entries queued -> next cycle dsp_valid=0, fifo_level=0, counters 0, cmd_ready=1.

Source files
------------

// File: rtl/llc_trace_dispatch.sv
// llc_trace_dispatch: buffers trace commands, splits addresses into tag/index and
// issues one LLC operation at a time; sequences clear/print and keeps op statistics.
module llc_trace_dispatch #(
   parameter int ADDR_W     = 32,
   parameter int OFFSET_W   = 6,
   parameter int INDEX_W    = 14,
   parameter int TAG_W      = ADDR_W - INDEX_W - OFFSET_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [3:0]                      cmd_op,
   input  logic [ADDR_W-1:0]               cmd_addr,
   output logic                            dsp_valid,
   input  logic                            dsp_ready,
   output logic [3:0]                      dsp_op,
   output logic                            dsp_snoop,
   output logic [ADDR_W-1:0]               dsp_addr,
   output logic [TAG_W-1:0]                dsp_tag,
   output logic [INDEX_W-1:0]              dsp_index,
   output logic                            clr_req,
   input  logic                            clr_done,
   output logic                            print_pulse,
   output logic                            bad_cmd,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [31:0]                     cnt_cpu_rd,
   output logic [31:0]                     cnt_cpu_wr,
   output logic [31:0]                     cnt_snoop,
   output logic [15:0]                     cnt_bad
);
   localparam int LW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, CLEAR} state_t;
   state_t state;
   logic [3:0] op_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [LW-1:0] wr_ptr, rd_ptr;
   logic push, pop;
   logic [3:0] head_op;
   logic [ADDR_W-1:0] head_addr;
   function automatic logic [31:0] sat32(input logic [31:0] v);
      return &v ? v : v + 32'd1;
   endfunction
   function automatic logic [15:0] sat16(input logic [15:0] v);
      return &v ? v : v + 16'd1;
   endfunction
   assign cmd_ready = fifo_level != (LW+1)'(FIFO_DEPTH);
   assign push = cmd_valid && cmd_ready;
   assign pop = state == IDLE && fifo_level != '0;
   assign head_op = op_mem[rd_ptr];
   assign head_addr = addr_mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr] <= cmd_op;
         addr_mem[wr_ptr] <= cmd_addr;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_level <= '0;
         dsp_valid <= 1'b0;
         dsp_op <= '0;
         dsp_snoop <= 1'b0;
         dsp_addr <= '0;
         dsp_tag <= '0;
         dsp_index <= '0;
         clr_req <= 1'b0;
         print_pulse <= 1'b0;
         bad_cmd <= 1'b0;
         cnt_cpu_rd <= '0;
         cnt_cpu_wr <= '0;
         cnt_snoop <= '0;
         cnt_bad <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         fifo_level <= fifo_level + (LW+1)'(push) - (LW+1)'(pop);
         print_pulse <= 1'b0;
         bad_cmd <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               if (head_op <= 4'd6) begin
                  dsp_valid <= 1'b1;
                  dsp_op <= head_op;
                  dsp_snoop <= head_op >= 4'd3;
                  dsp_addr <= head_addr;
                  dsp_tag <= head_addr[ADDR_W-1 -: TAG_W];
                  dsp_index <= head_addr[OFFSET_W +: INDEX_W];
                  state <= ISSUE;
               end else if (head_op == 4'd8) begin
                  clr_req <= 1'b1;
                  state <= CLEAR;
               end else if (head_op == 4'd9) begin
                  print_pulse <= 1'b1;
               end else begin
                  bad_cmd <= 1'b1;
                  cnt_bad <= sat16(cnt_bad);
               end
            end
            ISSUE: if (dsp_ready) begin
               dsp_valid <= 1'b0;
               state <= IDLE;
               if (dsp_snoop) cnt_snoop <= sat32(cnt_snoop);
               else if (dsp_op == 4'd1) cnt_cpu_wr <= sat32(cnt_cpu_wr);
               else cnt_cpu_rd <= sat32(cnt_cpu_rd);
            end
            CLEAR: if (clr_done) begin
               clr_req <= 1'b0;
               cnt_cpu_rd <= '0;
               cnt_cpu_wr <= '0;
               cnt_snoop <= '0;
               cnt_bad <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_llc_trace_dispatch.sv
// tb_llc_trace_dispatch: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_llc_trace_dispatch;
   localparam int DEPTH = 4;
   logic clk = 0, rst_n = 0, cmd_valid = 0, dsp_ready = 0, clr_done = 0;
   logic [3:0] cmd_op = 0;
   logic [31:0] cmd_addr = 0;
   logic cmd_ready, dsp_valid, dsp_snoop, clr_req, print_pulse, bad_cmd;
   logic [3:0] dsp_op;
   logic [31:0] dsp_addr, cnt_cpu_rd, cnt_cpu_wr, cnt_snoop;
   logic [11:0] dsp_tag;
   logic [13:0] dsp_index;
   logic [2:0] fifo_level;
   logic [15:0] cnt_bad;
   llc_trace_dispatch dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .dsp_valid(dsp_valid), .dsp_ready(dsp_ready),
      .dsp_op(dsp_op), .dsp_snoop(dsp_snoop), .dsp_addr(dsp_addr), .dsp_tag(dsp_tag),
      .dsp_index(dsp_index), .clr_req(clr_req), .clr_done(clr_done),
      .print_pulse(print_pulse), .bad_cmd(bad_cmd), .fifo_level(fifo_level),
      .cnt_cpu_rd(cnt_cpu_rd), .cnt_cpu_wr(cnt_cpu_wr), .cnt_snoop(cnt_snoop), .cnt_bad(cnt_bad)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0, nbad = 0, nprint = 0;
   bit en = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   typedef struct {logic [3:0] op; logic [31:0] addr;} cmd_t;
   cmd_t mq[$];
   int mode = 0;
   bit m_valid = 0, m_clr = 0, m_print = 0, m_bad = 0;
   logic [3:0] m_op = 0;
   logic [31:0] m_addr = 0, m_rd = 0, m_wr = 0, m_sn = 0;
   logic [15:0] m_badc = 0;
   // model: mode 0 waits for work, 1 offers an op, 2 waits for the clear handshake
   initial forever begin : mdl
      cmd_t h;
      bit pushed;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         mode = 0; m_valid = 0; m_clr = 0; m_print = 0; m_bad = 0;
         m_rd = 0; m_wr = 0; m_sn = 0; m_badc = 0;
      end else begin
         pushed = cmd_valid && mq.size() < DEPTH;
         m_print = 0;
         m_bad = 0;
         if (mode == 0 && mq.size() > 0) begin
            h = mq.pop_front();
            if (h.op <= 6) begin m_valid = 1; m_op = h.op; m_addr = h.addr; mode = 1; end
            else if (h.op == 8) begin m_clr = 1; mode = 2; end
            else if (h.op == 9) m_print = 1;
            else begin m_bad = 1; if (m_badc != 16'hFFFF) m_badc++; end
         end else if (mode == 1 && dsp_ready) begin
            m_valid = 0; mode = 0;
            if (m_op == 1) m_wr = (m_wr == '1) ? m_wr : m_wr + 1;
            else if (m_op >= 3) m_sn = (m_sn == '1) ? m_sn : m_sn + 1;
            else m_rd = (m_rd == '1) ? m_rd : m_rd + 1;
         end else if (mode == 2 && clr_done) begin
            m_clr = 0; mode = 0; m_rd = 0; m_wr = 0; m_sn = 0; m_badc = 0;
         end
         if (pushed) mq.push_back('{op: cmd_op, addr: cmd_addr});
      end
   end
   always @(negedge clk) if (en) begin
      chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
      chk("fifo_level", fifo_level, mq.size());
      chk("dsp_valid", dsp_valid, m_valid);
      if (m_valid) begin
         chk("dsp_op", dsp_op, m_op);
         chk("dsp_addr", dsp_addr, m_addr);
         chk("dsp_tag", dsp_tag, m_addr >> 20);
         chk("dsp_index", dsp_index, (m_addr >> 6) & 32'h3FFF);
         chk("dsp_snoop", dsp_snoop, m_op >= 3);
      end
      chk("clr_req", clr_req, m_clr);
      chk("print_pulse", print_pulse, m_print);
      chk("bad_cmd", bad_cmd, m_bad);
      chk("cnt_cpu_rd", cnt_cpu_rd, m_rd);
      chk("cnt_cpu_wr", cnt_cpu_wr, m_wr);
      chk("cnt_snoop", cnt_snoop, m_sn);
      chk("cnt_bad", cnt_bad, m_badc);
      if (bad_cmd) nbad++;
      if (print_pulse) nprint++;
   end
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask
   task automatic push(input logic [3:0] op, input logic [31:0] addr);
      int n = 0;
      bit ok;
      cmd_valid = 1; cmd_op = op; cmd_addr = addr;
      do begin
         @(negedge clk); ok = cmd_ready;
         @(posedge clk); #1; n++;
      end while (!ok && n < 200);
      cmd_valid = 0;
      chk("push_accepted", ok, 1);
   endtask
   task automatic wait_valid(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!dsp_valid && n < 50);
      chk(name, dsp_valid, 1);
   endtask
   initial begin
      int n;
      @(posedge clk); en = 1;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_dsp_valid", dsp_valid, 0);
      cyc(2);
      rst_n = 1;
      // basic CPU read
      dsp_ready = 1;
      push(4'd0, 32'h1234_5678);
      wait_valid("t1_valid");
      chk("t1_tag", dsp_tag, 12'h123);
      chk("t1_index", dsp_index, 14'h1159);
      chk("t1_snoop", dsp_snoop, 0);
      @(posedge clk); #1; cyc(3);
      chk("t1_cnt_rd", cnt_cpu_rd, 1);
      // stalled snoop
      dsp_ready = 0;
      push(4'd3, 32'hFFFF_FFC0);
      wait_valid("t2_valid");
      repeat (5) begin
         chk("t2_tag", dsp_tag, 12'hFFF);
         chk("t2_index", dsp_index, 14'h3FFF);
         chk("t2_snoop", dsp_snoop, 1);
         @(negedge clk);
      end
      @(posedge clk); #1; dsp_ready = 1; cyc(4);
      chk("t2_cnt_snoop", cnt_snoop, 1);
      // fill FIFO behind a stalled op
      dsp_ready = 0;
      push(4'd0, $urandom); push(4'd1, $urandom); push(4'd2, $urandom);
      push(4'd5, $urandom); push(4'd6, $urandom);
      chk("t3_full_level", fifo_level, 4);
      chk("t3_full_ready", cmd_ready, 0);
      dsp_ready = 1; cyc(15);
      chk("t3_cnt_rd", cnt_cpu_rd, 3);
      chk("t3_cnt_wr", cnt_cpu_wr, 1);
      chk("t3_cnt_snoop", cnt_snoop, 3);
      // illegal and print commands
      push(4'd7, $urandom); push(4'd9, $urandom); push(4'd12, $urandom);
      cyc(5);
      chk("t4_cnt_bad", cnt_bad, 2);
      chk("t4_bad_pulses", nbad, 2);
      chk("t4_print_pulses", nprint, 1);
      // clear with a pending op behind it
      push(4'd1, $urandom); push(4'd1, $urandom); push(4'd4, $urandom);
      push(4'd8, $urandom); push(4'd0, 32'hA5A5_0040);
      n = 0;
      do begin @(negedge clk); n++; end while (!clr_req && n < 50);
      chk("t5_clr_seen", clr_req, 1);
      chk("t5_cnt_wr_before", cnt_cpu_wr, 3);
      chk("t5_cnt_snoop_before", cnt_snoop, 4);
      repeat (3) begin
         @(negedge clk);
         chk("t5_clr_held", clr_req, 1);
         chk("t5_pending", dsp_valid, 0);
      end
      @(posedge clk); #1; clr_done = 1;
      @(posedge clk); #1; clr_done = 0;
      chk("t5_cnt_wr_cleared", cnt_cpu_wr, 0);
      chk("t5_cnt_bad_cleared", cnt_bad, 0);
      cyc(5);
      chk("t5_pending_done", cnt_cpu_rd, 1);
      // reset during issue
      dsp_ready = 0;
      push(4'd2, $urandom); push(4'd5, $urandom); push(4'd1, $urandom);
      chk("t6_level", fifo_level, 2);
      rst_n = 0; cyc(1);
      chk("t6_valid", dsp_valid, 0);
      chk("t6_level0", fifo_level, 0);
      chk("t6_ready", cmd_ready, 1);
      chk("t6_cnt_rd", cnt_cpu_rd, 0);
      rst_n = 1;
      // randomized traffic
      repeat (600) begin
         cmd_valid = ($urandom % 3) != 0;
         cmd_op = ($urandom % 10 == 0) ? 4'd8 : 4'($urandom % 16);
         cmd_addr = $urandom;
         dsp_ready = ($urandom % 3) != 0;
         clr_done = clr_req ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
         cyc(1);
      end
      cmd_valid = 0; dsp_ready = 1;
      repeat (60) begin clr_done = clr_req; cyc(1); end
      clr_done = 0; cyc(2);
      chk("drain_level", fifo_level, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
